// File: rtl/lcd_pkg.sv
// Shared constants for the LCD sequencer: flag indices, delay thresholds,
// init command table, DDRAM line addresses and FSM state encoding.
package lcd_pkg;

  localparam int NUM_FLAGS = 7;

  // Delay flag positions on drv_flags
  localparam int F_15000US = 0;
  localparam int F_4100US  = 1;
  localparam int F_1640US  = 2;
  localparam int F_100US   = 3;
  localparam int F_42US    = 4;
  localparam int F_250NS   = 5;
  localparam int F_40NS    = 6;

  localparam int NUM_INIT = 6;

  localparam logic [7:0] LINE1_ADDR = 8'h80;
  localparam logic [7:0] LINE2_ADDR = 8'hC0;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_SEND,
    INIT_WAIT,
    IDLE,
    ADDR_SEND,
    CHAR_SEND,
    POST_WAIT
  } state_e;

  // Delay of each flag in nanoseconds
  function automatic longint flag_ns(input int idx);
    case (idx)
      0:       return 15000000;
      1:       return 4100000;
      2:       return 1640000;
      3:       return 100000;
      4:       return 42000;
      5:       return 250;
      default: return 40;
    endcase
  endfunction

  // Cycle threshold for a flag, rounded up so a delay is never cut short
  function automatic int flag_cycles(input longint clk_hz, input int idx);
    return int'((clk_hz * flag_ns(idx) + 999999999) / 1000000000);
  endfunction

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h33;
      3'd1:    return 8'h32;
      3'd2:    return 8'h28;
      3'd3:    return 8'h0C;
      3'd4:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // Which flag ends the hold after each init byte
  function automatic logic [2:0] init_wait_flag(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'(F_4100US);
      3'd1:    return 3'(F_100US);
      3'd4:    return 3'(F_1640US);
      default: return 3'(F_42US);
    endcase
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Free-running saturating delay counter with one threshold comparator per flag.
module lcd_delay_timer
  import lcd_pkg::*;
#(
  parameter int CLK_HZ = 20000000,
  parameter int NFLAGS = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic [NFLAGS-1:0] flags
);

  // Wide enough to reach the longest (power-on) threshold
  localparam int TW = $clog2(flag_cycles(longint'(CLK_HZ), F_15000US) + 1);
  localparam logic [TW-1:0] CNT_MAX = '1;

  logic [TW-1:0] cnt_q, cnt_d;

  // Clear wins over counting; hold at the top instead of wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                  cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  for (genvar i = 0; i < NFLAGS; i++) begin : g_flag
    localparam logic [TW-1:0] THR = TW'(flag_cycles(longint'(CLK_HZ), i));
    assign flags[i] = (cnt_q >= THR);
  end

endmodule

// File: rtl/lcd_sequencer.sv
// HD44780-style 4-bit init and two-line redraw sequencer feeding a nibble driver.
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int CLK_HZ = 20000000,
  parameter int NFLAGS = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              refresh,
  output logic              busy,
  output logic [7:0]        drv_data,
  output logic              drv_rs,
  output logic              drv_enable,
  output logic [NFLAGS-1:0] drv_flags,
  input  logic              drv_count,
  input  logic              drv_rdy
);

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic [7:0]  data_q, data_d;
  logic        rs_q, rs_d;
  logic        low_q, low_d;      // drv_rdy has dropped during this transaction
  logic        pend_q, pend_d;
  logic        addr_q, addr_d;    // last byte sent was a line address
  logic [2:0]  init_idx_q, init_idx_d;
  logic [4:0]  char_idx_q, char_idx_d;
  logic        seq_clr;
  logic [4:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [7:0]  cbuf_q [32];

  lcd_delay_timer #(.CLK_HZ(CLK_HZ), .NFLAGS(NFLAGS)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   ((en_q & drv_count) | seq_clr),
    .flags (drv_flags)
  );

  // Character buffer: written any time, never reset
  always_ff @(posedge clk) begin
    if (wr_en) cbuf_q[wr_addr] <= wr_data;
  end

  // Address of the character the next transaction would carry
  always_comb begin
    rd_addr = char_idx_q;
    if (state_q == POST_WAIT && !addr_q) rd_addr = char_idx_q + 5'd1;
  end

  // Same-cycle write forwards so the byte launched is always the newest
  assign rd_data = (wr_en && wr_addr == rd_addr) ? wr_data : cbuf_q[rd_addr];

  // Next-state and transaction control
  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    data_d     = data_q;
    rs_d       = rs_q;
    low_d      = low_q;
    pend_d     = pend_q;
    addr_d     = addr_q;
    init_idx_d = init_idx_q;
    char_idx_d = char_idx_q;
    seq_clr    = 1'b0;
    if (refresh && state_q != IDLE) pend_d = 1'b1;
    case (state_q)
      PWR_WAIT: if (drv_flags[F_15000US]) begin
        state_d    = INIT_SEND;
        en_d       = 1'b1;
        data_d     = init_cmd(3'd0);
        rs_d       = 1'b0;
        init_idx_d = 3'd0;
        low_d      = 1'b0;
      end
      INIT_SEND, ADDR_SEND, CHAR_SEND: begin
        // Handshake: rdy must go low, then high, before the byte is done
        if (!low_q) begin
          if (!drv_rdy) low_d = 1'b1;
        end else if (drv_rdy) begin
          en_d    = 1'b0;
          low_d   = 1'b0;
          seq_clr = 1'b1;
          state_d = (state_q == INIT_SEND) ? INIT_WAIT : POST_WAIT;
        end
      end
      INIT_WAIT: if (drv_flags[init_wait_flag(init_idx_q)]) begin
        if (init_idx_q == 3'(NUM_INIT - 1)) begin
          state_d = IDLE;
        end else begin
          state_d    = INIT_SEND;
          init_idx_d = init_idx_q + 3'd1;
          en_d       = 1'b1;
          data_d     = init_cmd(init_idx_q + 3'd1);
          rs_d       = 1'b0;
        end
      end
      IDLE: if (refresh || pend_q) begin
        pend_d     = 1'b0;
        state_d    = ADDR_SEND;
        en_d       = 1'b1;
        data_d     = LINE1_ADDR;
        rs_d       = 1'b0;
        addr_d     = 1'b1;
        char_idx_d = 5'd0;
      end
      POST_WAIT: if (drv_flags[F_42US]) begin
        if (addr_q) begin
          state_d = CHAR_SEND;
          en_d    = 1'b1;
          data_d  = rd_data;
          rs_d    = 1'b1;
          addr_d  = 1'b0;
        end else if (char_idx_q == 5'd31) begin
          state_d    = IDLE;
          char_idx_d = 5'd0;
        end else if (char_idx_q == 5'd15) begin
          state_d    = ADDR_SEND;
          en_d       = 1'b1;
          data_d     = LINE2_ADDR;
          rs_d       = 1'b0;
          addr_d     = 1'b1;
          char_idx_d = 5'd16;
        end else begin
          state_d    = CHAR_SEND;
          en_d       = 1'b1;
          data_d     = rd_data;
          rs_d       = 1'b1;
          char_idx_d = char_idx_q + 5'd1;
        end
      end
      default: state_d = PWR_WAIT;
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PWR_WAIT;
      en_q       <= 1'b0;
      data_q     <= 8'h00;
      rs_q       <= 1'b0;
      low_q      <= 1'b0;
      pend_q     <= 1'b0;
      addr_q     <= 1'b0;
      init_idx_q <= 3'd0;
      char_idx_q <= 5'd0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      data_q     <= data_d;
      rs_q       <= rs_d;
      low_q      <= low_d;
      pend_q     <= pend_d;
      addr_q     <= addr_d;
      init_idx_q <= init_idx_d;
      char_idx_q <= char_idx_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign drv_enable = en_q;
  assign drv_data   = data_q;
  assign drv_rs     = rs_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Self-checking bench for lcd_sequencer, run at 1 MHz so delays equal microseconds.
module tb_lcd_sequencer;

  localparam int CLK_HZ = 1000000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       refresh = 1'b0;
  logic       busy;
  logic [7:0] drv_data;
  logic       drv_rs;
  logic       drv_enable;
  logic [6:0] drv_flags;
  logic       drv_count;
  logic       drv_rdy;

  lcd_sequencer #(.CLK_HZ(CLK_HZ), .NFLAGS(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .refresh    (refresh),
    .busy       (busy),
    .drv_data   (drv_data),
    .drv_rs     (drv_rs),
    .drv_enable (drv_enable),
    .drv_flags  (drv_flags),
    .drv_count  (drv_count),
    .drv_rdy    (drv_rdy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_tot++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
  endtask

  // Cycle index since reset release: 0 at the first edge with rst low
  int cyc = -1;
  initial forever begin
    @(posedge clk);
    if (rst) cyc = -1;
    else     cyc++;
  end

  // Driver model: after enable, drop rdy, then raise it again
  initial begin : drv_model
    int ds, dc;
    drv_rdy = 1'b1; drv_count = 1'b0; ds = 0; dc = 0;
    forever begin
      @(negedge clk);
      case (ds)
        0: if (drv_enable) begin drv_count = 1'b1; dc = 0; ds = 1; end
        1: begin drv_count = 1'b0; dc++; if (dc == 2) begin drv_rdy = 1'b0; dc = 0; ds = 2; end end
        2: begin dc++; if (dc == 3) begin drv_rdy = 1'b1; ds = 3; end end
        default: if (!drv_enable) ds = 0;
      endcase
    end
  end

  // Transaction monitor
  logic [7:0] lg_data [256];
  logic       lg_rs   [256];
  int         lg_rise [256];
  int         lg_fall [256];
  int nlog = 0, stab_err = 0, busy_fall = 0;
  initial begin : mon
    logic en_p, busy_p, rs_p;
    logic [7:0] d_p;
    en_p = 1'b0; busy_p = 1'b1; rs_p = 1'b0; d_p = '0;
    forever begin
      @(negedge clk);
      if (drv_enable && !en_p) begin
        if (nlog < 256) begin
          lg_data[nlog] = drv_data; lg_rs[nlog] = drv_rs; lg_rise[nlog] = cyc; lg_fall[nlog] = 0;
        end
        nlog++;
      end else if (drv_enable && (drv_data != d_p || drv_rs != rs_p)) stab_err++;
      if (!drv_enable && en_p && nlog > 0 && nlog <= 256) lg_fall[nlog-1] = cyc;
      if (!busy && busy_p) busy_fall = cyc;
      en_p = drv_enable; d_p = drv_data; rs_p = drv_rs; busy_p = busy;
    end
  end

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = 5'(a); wr_data = 8'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int t;
    t = 0;
    while (busy && t < lim) begin @(negedge clk); t++; end
    chk({nm, "_timeout"}, int'(busy), 0);
  endtask

  typedef struct { int idx; int c20m; int c1m; } thr_vec_t;
  typedef struct { logic [7:0] data; int gap; } init_vec_t;

  thr_vec_t  tv [7];
  init_vec_t iv [6];

  initial begin : main
    int b, t, p;
    tv[0] = '{0, 300000, 15000};
    tv[1] = '{1, 82000, 4100};
    tv[2] = '{2, 32800, 1640};
    tv[3] = '{3, 2000, 100};
    tv[4] = '{4, 840, 42};
    tv[5] = '{5, 5, 1};
    tv[6] = '{6, 1, 1};
    iv[0] = '{8'h33, 4100};
    iv[1] = '{8'h32, 100};
    iv[2] = '{8'h28, 42};
    iv[3] = '{8'h0C, 42};
    iv[4] = '{8'h01, 1640};
    iv[5] = '{8'h06, 42};

    // Threshold derivation at the default clock and at the bench clock
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("thr20m_%0d", i), lcd_pkg::flag_cycles(longint'(20000000), tv[i].idx), tv[i].c20m);
      chk($sformatf("thr1m_%0d", i), lcd_pkg::flag_cycles(longint'(CLK_HZ), tv[i].idx), tv[i].c1m);
    end

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_enable", int'(drv_enable), 0);
    chk("rst_data",   int'(drv_data), 0);
    chk("rst_rs",     int'(drv_rs), 0);
    chk("rst_busy",   int'(busy), 1);
    chk("rst_flags",  int'(drv_flags), 0);
    rst = 1'b0;

    // Power-on and init sequence
    wait_idle("init", 40000);
    chk("init_count", nlog, 6);
    chk_rng("first_en_cycle", lg_rise[0], 14999, 15001);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("init_byte%0d", i), int'({lg_rs[i], lg_data[i]}), int'({1'b0, iv[i].data}));
      if (i < 5) chk_rng($sformatf("init_gap%0d", i), lg_rise[i+1] - lg_fall[i], iv[i].gap, iv[i].gap + 5);
      else       chk_rng("init_gap5", busy_fall - lg_fall[5], iv[5].gap, iv[5].gap + 5);
    end

    // Full redraw of 'A'+i
    for (int i = 0; i < 32; i++) wr(i, 65 + i);
    b = nlog;
    pulse_refresh();
    wait_idle("redraw", 5000);
    chk("redraw_count", nlog - b, 34);
    chk("redraw_addr1", int'({lg_rs[b], lg_data[b]}), 9'h080);
    chk("redraw_addr2", int'({lg_rs[b+17], lg_data[b+17]}), 9'h0C0);
    for (int k = 0; k < 32; k++) begin
      p = (k < 16) ? k + 1 : k + 2;
      chk($sformatf("redraw_char%0d", k), int'({lg_rs[b+p], lg_data[b+p]}), 256 + 65 + k);
    end
    chk_rng("post_gap", lg_rise[b+1] - lg_fall[b], 42, 47);
    chk("redraw_busy", int'(busy), 0);

    // Two requests during a redraw merge into one more pass
    b = nlog;
    pulse_refresh();
    t = 0;
    while (nlog < b + 3 && t < 1000) begin @(negedge clk); t++; end
    pulse_refresh();
    repeat (5) @(negedge clk);
    pulse_refresh();
    t = 0;
    while (nlog < b + 68 && t < 10000) begin @(negedge clk); t++; end
    repeat (300) @(negedge clk);
    chk("merge_count", nlog - b, 68);
    chk("merge_second_addr", int'(lg_data[b+34]), 8'h80);
    chk("merge_last", int'({lg_rs[b+67], lg_data[b+67]}), 256 + 65 + 31);
    chk("merge_busy", int'(busy), 0);

    // Late write to addr 31 and a same-cycle write to addr 20
    b = nlog;
    pulse_refresh();
    t = 0;
    while (!(nlog >= b + 7 && drv_enable) && t < 2000) begin @(negedge clk); t++; end
    chk("char5_reached", nlog - b, 7);
    wr(31, 8'h5A);
    t = 0;
    while (!(nlog >= b + 22 && !drv_enable) && t < 3000) begin @(negedge clk); t++; end
    @(negedge clk);
    t = lg_fall[b+21];
    p = 0;
    while (cyc < t + 42 && p < 200) begin @(negedge clk); p++; end
    wr(20, 8'h7E);
    wait_idle("late_wr", 3000);
    chk("fwd_char20", int'({lg_rs[b+22], lg_data[b+22]}), 9'h17E);
    chk("late_char30", int'({lg_rs[b+32], lg_data[b+32]}), 256 + 65 + 30);
    chk("late_char31", int'({lg_rs[b+33], lg_data[b+33]}), 9'h15A);
    chk("stable_data", stab_err, 0);

    // Reset mid-transaction during char 10
    b = nlog;
    pulse_refresh();
    t = 0;
    while (!(nlog >= b + 12 && drv_enable) && t < 2000) begin @(negedge clk); t++; end
    chk("char10_reached", nlog - b, 12);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_enable", int'(drv_enable), 0);
    chk("midrst_busy", int'(busy), 1);
    chk("midrst_data", int'(drv_data), 0);
    @(negedge clk);
    rst = 1'b0;
    b = nlog;
    t = 0;
    while (nlog == b && t < 16000) begin @(negedge clk); t++; end
    @(negedge clk);
    chk("rerun_seen", nlog - b, 1);
    chk_rng("rerun_cycle", lg_rise[b], 14999, 15001);
    chk("rerun_byte", int'({lg_rs[b], lg_data[b]}), 9'h033);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
